// File: rtl/mem_access_ctrl.sv
// MEM-stage data-memory initiator: word loads with lane extension, word stores,
// and two-cycle read-modify-write for half-word and byte stores.
module mem_access_ctrl #(
    parameter int unsigned ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    input  logic [3:0]            req_op,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [31:0]           req_wdata,
    input  logic [31:0]           req_pc,
    output logic                  stall,
    output logic                  done,
    output logic                  misaligned,
    output logic [31:0]           load_data,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    output logic                  mem_we,
    output logic [31:0]           mem_pc,
    input  logic [31:0]           mem_rdata
);

    typedef enum logic {StIdle, StWrite} state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [31:0]           data_q, data_d;
    logic [31:0]           pc_q, pc_d;

    logic op_lw, op_lh, op_lhu, op_lb, op_lbu, op_sw, op_sh, op_sb;
    logic is_load, is_mem, sub_store, aligned;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] ld_ext;
    logic [31:0] merged;
    logic [ADDR_WIDTH-1:0] word_addr;

    assign word_addr = {req_addr[ADDR_WIDTH-1:2], 2'b00};

    // Decode the request opcode; unused encodings behave as NOP.
    always_comb begin
        op_lw  = 1'b0;
        op_lh  = 1'b0;
        op_lhu = 1'b0;
        op_lb  = 1'b0;
        op_lbu = 1'b0;
        op_sw  = 1'b0;
        op_sh  = 1'b0;
        op_sb  = 1'b0;
        case (req_op)
            4'd1:    op_lw  = 1'b1;
            4'd2:    op_lh  = 1'b1;
            4'd3:    op_lhu = 1'b1;
            4'd4:    op_lb  = 1'b1;
            4'd5:    op_lbu = 1'b1;
            4'd6:    op_sw  = 1'b1;
            4'd7:    op_sh  = 1'b1;
            4'd8:    op_sb  = 1'b1;
            default: ;
        endcase
    end

    assign is_load   = op_lw | op_lh | op_lhu | op_lb | op_lbu;
    assign sub_store = op_sh | op_sb;
    assign is_mem    = is_load | op_sw | sub_store;

    // Word ops need a 4-byte boundary, half ops a 2-byte one; bytes always fit.
    always_comb begin
        aligned = 1'b1;
        if (op_lw || op_sw) begin
            aligned = (req_addr[1:0] == 2'b00);
        end else if (op_lh || op_lhu || op_sh) begin
            aligned = ~req_addr[0];
        end
    end

    assign byte_sel = mem_rdata[{req_addr[1:0], 3'b000} +: 8];
    assign half_sel = mem_rdata[{req_addr[1], 4'b0000} +: 16];

    // Extend the addressed lane of the read word.
    always_comb begin
        ld_ext = mem_rdata;
        if (op_lh) begin
            ld_ext = {{16{half_sel[15]}}, half_sel};
        end else if (op_lhu) begin
            ld_ext = {16'h0000, half_sel};
        end else if (op_lb) begin
            ld_ext = {{24{byte_sel[7]}}, byte_sel};
        end else if (op_lbu) begin
            ld_ext = {24'h000000, byte_sel};
        end
    end

    // Splice the store lane into the current memory word for the RMW write-back.
    always_comb begin
        merged = mem_rdata;
        if (op_sh) begin
            merged[{req_addr[1], 4'b0000} +: 16] = req_wdata[15:0];
        end else begin
            merged[{req_addr[1:0], 3'b000} +: 8] = req_wdata[7:0];
        end
    end

    // Next state: an aligned SH/SB in IDLE latches its merged word and moves to WRITE.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        data_d  = data_q;
        pc_d    = pc_q;
        if (state_q == StWrite) begin
            state_d = StIdle;
        end else if (req_valid && sub_store && aligned) begin
            state_d = StWrite;
            addr_d  = word_addr;
            data_d  = merged;
            pc_d    = req_pc;
        end
    end

    // State and RMW latches with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            addr_q  <= '0;
            data_q  <= '0;
            pc_q    <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            pc_q    <= pc_d;
        end
    end

    // Memory port and pipeline handshake; reset suppresses all side effects.
    always_comb begin
        stall      = 1'b0;
        done       = 1'b0;
        misaligned = 1'b0;
        load_data  = '0;
        mem_addr   = word_addr;
        mem_wdata  = req_wdata;
        mem_we     = 1'b0;
        mem_pc     = req_pc;
        if (state_q == StWrite) begin
            // Request inputs still show the same store; they are ignored here.
            mem_addr  = addr_q;
            mem_wdata = data_q;
            mem_pc    = pc_q;
            if (!reset) begin
                mem_we = 1'b1;
                done   = 1'b1;
            end
        end else if (!reset && req_valid && is_mem) begin
            if (!aligned) begin
                misaligned = 1'b1;
            end else if (is_load) begin
                done      = 1'b1;
                load_data = ld_ext;
            end else if (op_sw) begin
                mem_we = 1'b1;
                done   = 1'b1;
            end else begin
                stall = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: directed vector table, hand-written RMW sequences
// and random requests checked against a byte-addressed memory model.
module tb_mem_access_ctrl;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic [3:0]  req_op;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [31:0] req_pc;
    logic        stall, done, misaligned, mem_we;
    logic [31:0] load_data, mem_addr, mem_wdata, mem_pc, mem_rdata;

    logic [31:0] mem [64];
    logic [7:0]  ref_bytes [256];

    int n_cmp = 0;
    int n_bad = 0;

    // Outputs captured mid-cycle by apply().
    logic        s_stall, s_done, s_mis, s_we;
    logic [31:0] s_ld, s_addr, s_wdata, s_pc;

    mem_access_ctrl #(.ADDR_WIDTH(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_op     (req_op),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_pc     (req_pc),
        .stall      (stall),
        .done       (done),
        .misaligned (misaligned),
        .load_data  (load_data),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_we     (mem_we),
        .mem_pc     (mem_pc),
        .mem_rdata  (mem_rdata)
    );

    assign mem_rdata = mem[mem_addr[7:2]];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    // Drive one cycle from a negedge, sample, then commit any memory write at the posedge.
    task automatic apply(input logic rst, input logic v, input logic [3:0] op,
                         input logic [31:0] a, input logic [31:0] wd, input logic [31:0] pc);
        reset = rst; req_valid = v; req_op = op; req_addr = a; req_wdata = wd; req_pc = pc;
        #1;
        s_stall = stall; s_done = done; s_mis = misaligned; s_we = mem_we;
        s_ld = load_data; s_addr = mem_addr; s_wdata = mem_wdata; s_pc = mem_pc;
        @(posedge clk);
        if (s_we) mem[s_addr[7:2]] = s_wdata;
        @(negedge clk);
    endtask

    function automatic int op_size(input logic [3:0] op);
        case (op)
            4'd1, 4'd6:       return 4;
            4'd2, 4'd3, 4'd7: return 2;
            4'd4, 4'd5, 4'd8: return 1;
            default:          return 0;
        endcase
    endfunction

    function automatic logic [31:0] ref_word(input logic [31:0] a);
        int b;
        b = int'(a[7:2]) * 4;
        return {ref_bytes[b+3], ref_bytes[b+2], ref_bytes[b+1], ref_bytes[b]};
    endfunction

    function automatic logic [31:0] ref_load(input logic [3:0] op, input logic [31:0] a);
        longint v;
        int     sz;
        int     b;
        sz = op_size(op);
        b  = int'(a[7:0]);
        v  = 0;
        for (int i = 0; i < sz; i++) v += longint'(ref_bytes[b+i]) << (8 * i);
        if ((op == 4'd2 || op == 4'd4) && v >= (longint'(1) << (8 * sz - 1)))
            v -= longint'(1) << (8 * sz);
        return v[31:0];
    endfunction

    typedef struct {
        logic [3:0]  op;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        done;
        logic        mis;
        logic        we;
        logic [31:0] ld;
    } vec_t;

    vec_t vecs [11];

    initial begin
        logic [31:0] w, exp_w, exp_ld;
        logic [3:0]  op;
        logic        v;
        int          sz;

        vecs[0]  = '{4'd1,  32'h08, 32'h0,        32'h8899AABB, 1'b1, 1'b0, 1'b0, 32'h8899AABB};
        vecs[1]  = '{4'd4,  32'h13, 32'h0,        32'h80FF1234, 1'b1, 1'b0, 1'b0, 32'hFFFFFF80};
        vecs[2]  = '{4'd5,  32'h13, 32'h0,        32'h80FF1234, 1'b1, 1'b0, 1'b0, 32'h00000080};
        vecs[3]  = '{4'd2,  32'h12, 32'h0,        32'h80FF1234, 1'b1, 1'b0, 1'b0, 32'hFFFF80FF};
        vecs[4]  = '{4'd3,  32'h12, 32'h0,        32'h80FF1234, 1'b1, 1'b0, 1'b0, 32'h000080FF};
        vecs[5]  = '{4'd1,  32'h06, 32'h0,        32'h12345678, 1'b0, 1'b1, 1'b0, 32'h0};
        vecs[6]  = '{4'd6,  32'h01, 32'h55,       32'h12345678, 1'b0, 1'b1, 1'b0, 32'h0};
        vecs[7]  = '{4'd7,  32'h03, 32'h55,       32'h12345678, 1'b0, 1'b1, 1'b0, 32'h0};
        vecs[8]  = '{4'd6,  32'h04, 32'hCAFEF00D, 32'h0,        1'b1, 1'b0, 1'b1, 32'h0};
        vecs[9]  = '{4'd0,  32'h08, 32'h0,        32'h8899AABB, 1'b0, 1'b0, 1'b0, 32'h0};
        vecs[10] = '{4'd12, 32'h08, 32'h0,        32'h8899AABB, 1'b0, 1'b0, 1'b0, 32'h0};

        for (int i = 0; i < 64; i++) mem[i] = 32'h0;
        reset = 1'b1; req_valid = 1'b0; req_op = 4'd0;
        req_addr = '0; req_wdata = '0; req_pc = '0;
        @(negedge clk);

        // Reset holds outputs quiet even with a valid load presented.
        mem[2] = 32'h8899AABB;
        apply(1'b1, 1'b1, 4'd1, 32'h8, 32'h0, 32'h100);
        chk("rst_done", {31'b0, s_done}, 32'h0);
        chk("rst_stall", {31'b0, s_stall}, 32'h0);
        chk("rst_mis", {31'b0, s_mis}, 32'h0);
        chk("rst_we", {31'b0, s_we}, 32'h0);
        chk("rst_ld", s_ld, 32'h0);

        // Directed single-cycle vectors.
        for (int i = 0; i < 11; i++) begin
            mem[vecs[i].addr[7:2]] = vecs[i].rdata;
            apply(1'b0, 1'b1, vecs[i].op, vecs[i].addr, vecs[i].wdata, 32'h200 + i);
            chk($sformatf("vec%0d_done", i), {31'b0, s_done}, {31'b0, vecs[i].done});
            chk($sformatf("vec%0d_mis", i), {31'b0, s_mis}, {31'b0, vecs[i].mis});
            chk($sformatf("vec%0d_we", i), {31'b0, s_we}, {31'b0, vecs[i].we});
            chk($sformatf("vec%0d_stall", i), {31'b0, s_stall}, 32'h0);
            if (vecs[i].done && !vecs[i].we) begin
                chk($sformatf("vec%0d_ld", i), s_ld, vecs[i].ld);
                chk($sformatf("vec%0d_addr", i), s_addr, {vecs[i].addr[31:2], 2'b00});
            end
        end
        chk("sw_mem", mem[1], 32'hCAFEF00D);

        // SB at 0x21 over 0x11223344, then readback.
        mem[8] = 32'h11223344;
        apply(1'b0, 1'b1, 4'd8, 32'h21, 32'hAB, 32'h400);
        chk("sb_c1_stall", {31'b0, s_stall}, 32'h1);
        chk("sb_c1_we", {31'b0, s_we}, 32'h0);
        apply(1'b0, 1'b1, 4'd8, 32'h21, 32'hAB, 32'h400);
        chk("sb_c2_we", {31'b0, s_we}, 32'h1);
        chk("sb_c2_addr", s_addr, 32'h20);
        chk("sb_c2_wdata", s_wdata, 32'h1122AB44);
        chk("sb_c2_pc", s_pc, 32'h400);
        chk("sb_c2_done", {31'b0, s_done}, 32'h1);
        chk("sb_c2_stall", {31'b0, s_stall}, 32'h0);
        apply(1'b0, 1'b1, 4'd1, 32'h20, 32'h0, 32'h404);
        chk("sb_readback", s_ld, 32'h1122AB44);

        // SH at 0x22.
        mem[8] = 32'h11223344;
        apply(1'b0, 1'b1, 4'd7, 32'h22, 32'hBEEF, 32'h408);
        chk("sh_c1_stall", {31'b0, s_stall}, 32'h1);
        apply(1'b0, 1'b1, 4'd7, 32'h22, 32'hBEEF, 32'h408);
        chk("sh_c2_wdata", s_wdata, 32'hBEEF3344);

        // Back-to-back SB then SW: only the SB stalls.
        mem[9] = 32'h0;
        apply(1'b0, 1'b1, 4'd8, 32'h24, 32'h77, 32'h500);
        chk("b2b_sb_stall", {31'b0, s_stall}, 32'h1);
        apply(1'b0, 1'b1, 4'd8, 32'h24, 32'h77, 32'h500);
        chk("b2b_sb_we", {31'b0, s_we}, 32'h1);
        chk("b2b_sb_stall2", {31'b0, s_stall}, 32'h0);
        apply(1'b0, 1'b1, 4'd6, 32'h28, 32'hDEADBEEF, 32'h504);
        chk("b2b_sw_we", {31'b0, s_we}, 32'h1);
        chk("b2b_sw_stall", {31'b0, s_stall}, 32'h0);
        chk("b2b_sw_pc", s_pc, 32'h504);
        chk("b2b_mem_sb", mem[9], 32'h00000077);
        chk("b2b_mem_sw", mem[10], 32'hDEADBEEF);

        // Reset during WRITE cancels the write.
        mem[12] = 32'hA5A5A5A5;
        apply(1'b0, 1'b1, 4'd8, 32'h30, 32'h11, 32'h600);
        apply(1'b1, 1'b1, 4'd8, 32'h30, 32'h11, 32'h600);
        chk("rstw_we", {31'b0, s_we}, 32'h0);
        chk("rstw_done", {31'b0, s_done}, 32'h0);
        chk("rstw_mem", mem[12], 32'hA5A5A5A5);
        apply(1'b0, 1'b1, 4'd1, 32'h30, 32'h0, 32'h604);
        chk("rstw_lw_done", {31'b0, s_done}, 32'h1);
        chk("rstw_lw_ld", s_ld, 32'hA5A5A5A5);
        chk("rstw_lw_stall", {31'b0, s_stall}, 32'h0);

        // Random requests against the byte-level model.
        for (int i = 0; i < 64; i++) begin
            mem[i] = $urandom;
            for (int k = 0; k < 4; k++) ref_bytes[4*i+k] = mem[i][8*k +: 8];
        end
        for (int n = 0; n < 400; n++) begin
            logic [31:0] a, wd, pc;
            op = 4'($urandom_range(0, 15));
            v  = ($urandom_range(0, 7) != 0);
            a  = $urandom; wd = $urandom; pc = $urandom;
            sz = v ? op_size(op) : 0;
            apply(1'b0, v, op, a, wd, pc);
            if (sz == 0) begin
                chk("rnd_idle_act", {29'b0, s_done, s_stall, s_we}, 32'h0);
                chk("rnd_idle_mis", {31'b0, s_mis}, 32'h0);
            end else if ((int'(a[1:0]) % sz) != 0) begin
                chk("rnd_mis", {28'b0, s_mis, s_done, s_stall, s_we}, 32'h8);
            end else if (op <= 4'd5) begin
                exp_ld = ref_load(op, a);
                chk("rnd_ld_flags", {28'b0, s_mis, s_done, s_stall, s_we}, 32'h4);
                chk("rnd_ld", s_ld, exp_ld);
                chk("rnd_ld_addr", s_addr, {a[31:2], 2'b00});
            end else begin
                for (int k = 0; k < sz; k++) ref_bytes[int'(a[7:0]) + k] = wd[8*k +: 8];
                exp_w = ref_word(a);
                if (sz == 4) begin
                    chk("rnd_sw_flags", {28'b0, s_mis, s_done, s_stall, s_we}, 32'h5);
                end else begin
                    chk("rnd_rmw1_flags", {28'b0, s_mis, s_done, s_stall, s_we}, 32'h2);
                    apply(1'b0, v, op, a, wd, pc);
                    chk("rnd_rmw2_flags", {28'b0, s_mis, s_done, s_stall, s_we}, 32'h5);
                end
                chk("rnd_st_addr", s_addr, {a[31:2], 2'b00});
                chk("rnd_st_wdata", s_wdata, exp_w);
                chk("rnd_st_pc", s_pc, pc);
            end
        end
        for (int i = 0; i < 64; i++) begin
            w = {ref_bytes[4*i+3], ref_bytes[4*i+2], ref_bytes[4*i+1], ref_bytes[4*i]};
            chk($sformatf("final_mem%0d", i), mem[i], w);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
